// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types; fwd_tag_t is the per-stage producer tag
// carried alongside the pipeline for operand forwarding decisions.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef struct packed {
        logic    valid;
        lc3b_reg dest;
        logic    write;
        logic    is_load;
    } fwd_tag_t;

    localparam fwd_tag_t FWD_BUBBLE = '{valid: 1'b0, dest: '0, write: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/fwd_match.sv
// One consumer operand against every older producer stage; combinational,
// picks the youngest (lowest-index) matching stage, 0 means register file.
module fwd_match #(
    parameter int NUM_STAGES = 3,
    parameter int REG_W      = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES)
)(
    input  logic                              consumer_vld_i,
    input  logic [REG_W-1:0]                  src_i,
    input  logic [NUM_STAGES-1:1]             prod_vld_i,
    input  logic [NUM_STAGES-1:1][REG_W-1:0]  prod_dest_i,
    output logic [SEL_W-1:0]                  sel_o
);

    // Walk oldest to youngest so the youngest hit is the last assignment.
    always_comb begin
        sel_o = '0;
        if (consumer_vld_i) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                if (prod_vld_i[k] && (prod_dest_i[k] == src_i)) begin
                    sel_o = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/forward_unit_n.sv
// Forwarding/hazard unit: tracks producer tags after ID, selects EX operand
// sources combinationally and raises a one-advance load-use stall.
module forward_unit_n
    import lc3b_types::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int REG_W      = 3,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(NUM_STAGES)
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            id_valid,
    input  logic [NUM_SRC-1:0][REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]              id_src_used,
    input  logic [REG_W-1:0]                id_dest,
    input  logic                            id_write,
    input  logic                            id_is_load,
    input  logic                            advance,
    input  logic                            flush,
    output logic [NUM_SRC-1:0][SEL_W-1:0]   fwd_sel,
    output logic                            stall,
    output logic [CNT_W-1:0]                stall_count
);

    fwd_tag_t                       tag_q  [NUM_STAGES];
    fwd_tag_t                       tag_d  [NUM_STAGES];
    logic [NUM_SRC-1:0][REG_W-1:0]  src_q  [NUM_STAGES];
    logic [NUM_SRC-1:0][REG_W-1:0]  src_d  [NUM_STAGES];
    logic [NUM_SRC-1:0]             used_q [NUM_STAGES];
    logic [NUM_SRC-1:0]             used_d [NUM_STAGES];
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;

    logic                           ld_hit;
    logic                           id_take;

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src[i] == REG_W'(tag_q[0].dest))) begin
                ld_hit = 1'b1;
            end
        end
        stall = id_valid && !flush && tag_q[0].valid && tag_q[0].write
                && tag_q[0].is_load && ld_hit;
    end

    assign id_take = id_valid && !stall && !flush;

    // A frozen pipeline holds every tag, so stall/flush cannot touch state.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            tag_d[k]  = tag_q[k];
            src_d[k]  = src_q[k];
            used_d[k] = used_q[k];
        end
        cnt_d = cnt_q;

        if (advance) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                tag_d[k]  = tag_q[k-1];
                src_d[k]  = src_q[k-1];
                used_d[k] = used_q[k-1];
            end
            if (id_take) begin
                tag_d[0]  = '{valid: 1'b1, dest: lc3b_reg'(id_dest),
                              write: id_write, is_load: id_is_load};
                src_d[0]  = id_src;
                used_d[0] = id_src_used;
            end else begin
                tag_d[0]  = FWD_BUBBLE;
                src_d[0]  = '0;
                used_d[0] = '0;
            end
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                tag_q[k]  <= FWD_BUBBLE;
                src_q[k]  <= '0;
                used_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            tag_q  <= tag_d;
            src_q  <= src_d;
            used_q <= used_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

    logic [NUM_STAGES-1:1]            prod_vld;
    logic [NUM_STAGES-1:1][REG_W-1:0] prod_dest;

    always_comb begin
        for (int k = 1; k < NUM_STAGES; k++) begin
            prod_vld[k]  = tag_q[k].valid && tag_q[k].write;
            prod_dest[k] = REG_W'(tag_q[k].dest);
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_W      (REG_W),
            .SEL_W      (SEL_W)
        ) u_match (
            .consumer_vld_i (tag_q[0].valid && used_q[0][i]),
            .src_i          (src_q[0][i]),
            .prod_vld_i     (prod_vld),
            .prod_dest_i    (prod_dest),
            .sel_o          (fwd_sel[i])
        );
    end

endmodule

// File: tb/tb_forward_unit_n.sv
// Directed and randomized checks of forward_unit_n against a queue-based pipeline model.
module tb_forward_unit_n;

    localparam int NS = 3;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [1:0][2:0]  id_src;
    logic [1:0]       id_src_used;
    logic [2:0]       id_dest;
    logic             id_write;
    logic             id_is_load;
    logic             advance;
    logic             flush;
    logic [1:0][1:0]  fwd_sel;
    logic             stall;
    logic [15:0]      stall_count;
    logic [1:0][1:0]  fwd_sel2;
    logic             stall2;
    logic [1:0]       cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    forward_unit_n dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dest(id_dest), .id_write(id_write),
        .id_is_load(id_is_load), .advance(advance), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
    );

    forward_unit_n #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dest(id_dest), .id_write(id_write),
        .id_is_load(id_is_load), .advance(advance), .flush(flush),
        .fwd_sel(fwd_sel2), .stall(stall2), .stall_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 is EX, one record per tracked stage.
    typedef struct {
        bit v; int dest; bit wr; bit ld;
        int src0; int src1; bit u0; bit u1;
    } ent_t;

    ent_t pipe[$];
    int   m16;
    int   m2;

    function automatic ent_t bubble();
        ent_t e;
        e = '{v: 0, dest: 0, wr: 0, ld: 0, src0: 0, src1: 0, u0: 0, u1: 0};
        return e;
    endfunction

    function automatic int exp_sel(int i);
        int s;
        bit u;
        s = (i == 0) ? pipe[0].src0 : pipe[0].src1;
        u = (i == 0) ? pipe[0].u0 : pipe[0].u1;
        if (!pipe[0].v || !u) return 0;
        for (int k = 1; k < NS; k++)
            if (pipe[k].v && pipe[k].wr && pipe[k].dest == s) return k;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit hit;
        hit = (id_src_used[0] && int'(id_src[0]) == pipe[0].dest)
           || (id_src_used[1] && int'(id_src[1]) == pipe[0].dest);
        return id_valid && !flush && pipe[0].v && pipe[0].wr && pipe[0].ld && hit;
    endfunction

    task automatic cycle();
        bit   st;
        ent_t e;
        st = exp_stall();
        @(posedge clk);
        if (!rst_n) begin
            foreach (pipe[k]) pipe[k] = bubble();
            m16 = 0;
            m2  = 0;
        end else if (advance) begin
            e = bubble();
            if (id_valid && !st && !flush) begin
                e.v = 1; e.dest = int'(id_dest); e.wr = id_write; e.ld = id_is_load;
                e.src0 = int'(id_src[0]); e.src1 = int'(id_src[1]);
                e.u0 = id_src_used[0]; e.u1 = id_src_used[1];
            end
            pipe.push_front(e);
            void'(pipe.pop_back());
            if (st) begin
                if (m16 < 65535) m16++;
                if (m2 < 3) m2++;
            end
        end
        #1;
    endtask

    task automatic set_id(bit v, int d, bit w, bit l, int s0, bit u0, int s1, bit u1);
        logic [31:0] t0, t1, td;
        t0 = s0; t1 = s1; td = d;
        id_valid = v; id_dest = td[2:0]; id_write = w; id_is_load = l;
        id_src[0] = t0[2:0]; id_src[1] = t1[2:0];
        id_src_used = {u1, u0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0; advance = 1'b1; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; advance = 1'b1; flush = 1'b0;
        set_id(1, 1, 1, 1, 1, 1, 1, 1);
        cycle();
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall); end
        n_checks++; if (fwd_sel !== 4'h0) begin n_fail++; $display("FAIL reset_fwd got %h want 0", fwd_sel); end
        n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", stall_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_forward_basic();
        do_reset();
        set_id(1, 1, 1, 0, 0, 0, 0, 0);        // ADD R1
        cycle();
        set_id(1, 6, 1, 0, 1, 1, 5, 1);        // ADD R6 <- R1, R5
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (fwd_sel[0] !== 2'd1) begin n_fail++; $display("FAIL fwd_basic_src0 got %0d want 1", fwd_sel[0]); end
        n_checks++; if (fwd_sel[1] !== 2'd0) begin n_fail++; $display("FAIL fwd_basic_src1 got %0d want 0", fwd_sel[1]); end
    endtask

    task automatic test_youngest();
        do_reset();
        set_id(1, 2, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 2, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 0, 0, 0, 2, 1, 0, 0);
        cycle();
        @(negedge clk);
        n_checks++; if (fwd_sel[0] !== 2'd1) begin n_fail++; $display("FAIL youngest_wins got %0d want 1", fwd_sel[0]); end
        set_id(1, 2, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 7, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 0, 0, 0, 2, 1, 7, 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (fwd_sel[0] !== 2'd2) begin n_fail++; $display("FAIL only_stage2 got %0d want 2", fwd_sel[0]); end
        n_checks++; if (fwd_sel[1] !== 2'd1) begin n_fail++; $display("FAIL other_src_stage1 got %0d want 1", fwd_sel[1]); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 3, 1, 1, 0, 0, 0, 0);        // LDR R3
        cycle();
        set_id(1, 0, 1, 0, 3, 1, 1, 0);        // consumer of R3
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0d want 1", stall); end
        n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL lu_cnt_before got %0d want 0", stall_count); end
        cycle();
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_drop got %0d want 0", stall); end
        n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_after got %0d want 1", stall_count); end
        n_checks++; if (fwd_sel[0] !== 2'd0) begin n_fail++; $display("FAIL lu_bubble_fwd got %0d want 0", fwd_sel[0]); end
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        // Load has reached stage 2 behind the inserted bubble.
        n_checks++; if (fwd_sel[0] !== 2'd2) begin n_fail++; $display("FAIL lu_consumer_fwd got %0d want 2", fwd_sel[0]); end
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(1, 3, 1, 1, 0, 0, 0, 0);
        cycle();
        set_id(1, 0, 1, 0, 0, 0, 3, 1);
        advance = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL freeze_stall c%0d got %0d want 1", c, stall); end
            n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL freeze_cnt c%0d got %0d want 0", c, stall_count); end
            cycle();
        end
        advance = 1'b1;
        cycle();
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL freeze_release got %0d want 0", stall); end
        n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL freeze_cnt_after got %0d want 1", stall_count); end
    endtask

    task automatic test_flush_and_unused();
        do_reset();
        set_id(1, 4, 1, 1, 0, 0, 0, 0);
        cycle();
        set_id(1, 0, 1, 0, 4, 1, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %0d want 0", stall); end
        cycle();
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (fwd_sel[0] !== 2'd0) begin n_fail++; $display("FAIL flush_bubble got %0d want 0", fwd_sel[0]); end
        n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL flush_cnt got %0d want 0", stall_count); end
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 0, 0, 0, 5, 0, 5, 0);
        cycle();
        set_id(1, 6, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (fwd_sel !== 4'h0) begin n_fail++; $display("FAIL unused_fwd got %h want 0", fwd_sel); end
        cycle();
        set_id(1, 0, 0, 0, 6, 0, 6, 0);
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall got %0d want 0", stall); end
        cycle();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int n = 0; n < 5; n++) begin
            set_id(1, 3, 1, 1, 0, 0, 0, 0);
            cycle();
            set_id(1, 1, 1, 0, 3, 1, 3, 1);
            @(negedge clk);
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall n%0d got %0d want 1", n, stall); end
            cycle();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL sat_cnt16 got %0d want 5", stall_count); end
        n_checks++; if (cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2 got %0d want 3", cnt2); end
    endtask

    task automatic test_reset_midstream();
        set_id(1, 1, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 2, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 3, 1, 1, 0, 0, 0, 0);
        cycle();
        set_id(1, 0, 1, 0, 3, 1, 1, 1);
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall got %0d want 1", stall); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (fwd_sel !== 4'h0) begin n_fail++; $display("FAIL mid_fwd got %h want 0", fwd_sel); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %0d want 0", stall); end
        n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", stall_count); end
        n_checks++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL mid_cnt2 got %0d want 0", cnt2); end
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            advance = ($urandom_range(0, 9) < 8);
            flush   = ($urandom_range(0, 9) == 0);
            set_id(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1));
            @(negedge clk);
            n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d got %0d want %0d", c, stall, exp_stall()); end
            n_checks++; if (int'(fwd_sel[0]) != exp_sel(0)) begin n_fail++; $display("FAIL rnd_fwd0 c%0d got %0d want %0d", c, fwd_sel[0], exp_sel(0)); end
            n_checks++; if (int'(fwd_sel[1]) != exp_sel(1)) begin n_fail++; $display("FAIL rnd_fwd1 c%0d got %0d want %0d", c, fwd_sel[1], exp_sel(1)); end
            n_checks++; if (int'(stall_count) != m16) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, stall_count, m16); end
            n_checks++; if (int'(cnt2) != m2) begin n_fail++; $display("FAIL rnd_cnt2 c%0d got %0d want %0d", c, cnt2, m2); end
            n_checks++; if ({fwd_sel2, stall2} !== {fwd_sel, stall}) begin n_fail++; $display("FAIL rnd_dut2 c%0d got %h want %h", c, {fwd_sel2, stall2}, {fwd_sel, stall}); end
            cycle();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NS; k++) pipe.push_back(bubble());
        m16 = 0;
        m2  = 0;
        rst_n = 1'b0; advance = 1'b1; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_forward_basic();
        test_youngest();
        test_load_use();
        test_freeze();
        test_flush_and_unused();
        test_saturate();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
